pci_initiator: RTL and testbench
================================

Name: pci_initiator

Overview:
- PCI bus master that issues single-address burst READ and WRITE transactions to targets on the shared 32-bit AD bus.
- Pairs with the existing PCI target device: it drives FRAME, IRDY, AD and CBE, and samples TRDY and DEVSEL.
- A local request port starts a burst. Write data is pulled from the local side and read data is pushed to it.
- Performs master abort when no target claims the address within the timeout.

Parameters:
- DEVSEL_TIMEOUT, 4, clocks after the address phase in which DEVSEL must go low; otherwise master abort.
- MAX_WORDS, 32, largest burst length accepted.

Ports:
- CLK  in  1  bus clock.
- REST  in  1  reset.
- START  in  1  one-cycle request pulse; sampled only in IDLE.
- ADDR  in  32  start address.
- CMD  in  4  bus command; 0110 READ, 0111 WRITE.
- BE  in  4  active-low byte enables, used for every data phase.
- NWORDS  in  6  burst length, 1..MAX_WORDS.
- WR_DATA  in  32  current write word; held stable until WR_POP.
- WR_POP  out  1  write word consumed this cycle.
- RD_DATA  out  32  read word, registered.
- RD_VALID  out  1  RD_DATA valid this cycle.
- BUSY  out  1  transaction in progress.
- DONE  out  1  one-cycle pulse, normal completion.
- ABORT  out  1  one-cycle pulse, master abort.
- FRAME  out  1  active low; Z when bus released.
- IRDY  out  1  active low; Z when bus released.
- CBE  out  4  command / byte enables; Z when released.
- TRDY  in  1  active low, from target.
- DEVSEL  in  1  active low, from target.
- AD  inout  32  address/data.

Interface decision: one clock (CLK); reset REST is synchronous and active-high.

Behaviour:
- Reset (REST high at a CLK posedge): state IDLE. FRAME, IRDY, CBE and AD all Z. WR_POP, RD_VALID, BUSY, DONE, ABORT = 0. RD_DATA = 0.
- Reset mid-burst: bus released on the next edge with no RELEASE cycle and no DONE or ABORT pulse.

State IDLE:
- Bus released. BUSY = 0.
- START=1 with 1 ≤ NWORDS ≤ MAX_WORDS: latch ADDR, CMD, BE, NWORDS, then go to ADDR.
- START with NWORDS = 0 or NWORDS > MAX_WORDS is ignored; no pulse is produced.

State ADDR (one cycle):
- FRAME=0, IRDY=1, AD=latched ADDR, CBE=latched CMD. BUSY=1.
- Clear the DEVSEL timer. Go to DATA.

State DATA:
- IRDY=0, CBE=latched BE.
- Direction is CMD[0]: 1 = write, 0 = read.
- Write: AD=WR_DATA, combinational pass-through.
- Read: AD=Z. The first DATA cycle doubles as the turnaround.
- FRAME=0 while remaining > 1. FRAME=1 while remaining == 1 (last data phase; IRDY stays 0).
- A transfer occurs at a posedge with IRDY=0, TRDY=0 and DEVSEL=0. On a transfer:
  - remaining decrements.
  - Write: WR_POP=1 that cycle.
  - Read: RD_DATA<=AD and RD_VALID=1 on the next cycle.
- Wait states: TRDY high means hold every output unchanged; no timeout while DEVSEL is low.
- Transfer with remaining == 1: go to RELEASE, DONE=1.

DEVSEL timer:
- Counts DATA cycles while DEVSEL is high.
- Reaches DEVSEL_TIMEOUT with DEVSEL still high: go to RELEASE, ABORT=1. No WR_POP or RD_VALID is produced in the aborted burst.
- DEVSEL sampled low once: the timer freezes for the rest of the burst.

State RELEASE (one cycle):
- FRAME=1 and IRDY=1 driven (not Z). AD and CBE Z. BUSY=1.
- Then IDLE, where FRAME and IRDY go Z.

Boundaries:
- NWORDS=1: FRAME goes high in the first DATA cycle.
- START while BUSY is ignored.
- remaining is a 6-bit down-counter that never wraps below 1.
- The initiator generates no address increment on AD; the target advances its own index.

Decomposition:
- Package pci_pkg:
  - Command constants PCI_CMD_READ=4'b0110 and PCI_CMD_WRITE=4'b0111.
  - State enum IDLE/ADDR/DATA/RELEASE.
  - DEVSEL_TIMEOUT default.
  - Shared with the target device.
- One natural sub-module, pci_devsel_timer:
  - clear, count enable, DEVSEL sample, expire output.
  - Everything else is a single FSM plus the remaining counter.

Test Plan:
- Write, 4 words: ADDR=0000FFFF, CMD=0111, BE=0000, NWORDS=4, data 11,22,33,44, target with fast DEVSEL/TRDY -> 4 WR_POP pulses; FRAME high during the 4th data phase; DONE one cycle after; target MEM[0..3]=11,22,33,44.
- Read back with CMD=0110, NWORDS=4 -> AD Z in the first DATA cycle; RD_VALID pulses carry 11,22,33,44; DONE.
- Target holds TRDY high for 2 cycles before each transfer -> AD, CBE, FRAME and IRDY stable through the wait states; 4 transfers; DONE only after the 4th.
- ADDR=12345678 (no target) -> DEVSEL never low; ABORT pulses after 4 DATA cycles; no WR_POP; bus Z two cycles later.
- NWORDS=1 write, then START with NWORDS=0 -> single phase with FRAME=1 and IRDY=0 together, then DONE; the NWORDS=0 request is ignored and BUSY stays 0.
- REST=1 asserted in the 2nd data phase of an 8-word write -> next edge FRAME, IRDY, AD and CBE are Z; no DONE or ABORT; a new START then runs normally.

Source files
------------

// File: rtl/pci_pkg.sv
// pci_pkg: PCI command codes, bus states and timing defaults shared by initiator and target
package pci_pkg;
  localparam logic [3:0] PCI_CMD_READ = 4'b0110;
  localparam logic [3:0] PCI_CMD_WRITE = 4'b0111;
  localparam int PCI_DEVSEL_TIMEOUT = 4;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RELEASE} pci_state_e;
endpackage

// File: rtl/pci_devsel_timer.sv
// pci_devsel_timer: counts data cycles without DEVSEL and flags a master abort
module pci_devsel_timer #(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic devsel,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  logic seen;
  assign expire = en && devsel && !seen && cnt == W'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt <= '0;
      seen <= 1'b0;
    end else if (en) begin
      seen <= seen | ~devsel;
      if (devsel && !seen) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pci_initiator.sv
// pci_initiator: PCI bus master issuing single-address READ/WRITE bursts with master abort
module pci_initiator import pci_pkg::*; #(
  parameter int DEVSEL_TIMEOUT = PCI_DEVSEL_TIMEOUT,
  parameter int MAX_WORDS = 32
) (
  input  logic        CLK,
  input  logic        REST,
  input  logic        START,
  input  logic [31:0] ADDR,
  input  logic [3:0]  CMD,
  input  logic [3:0]  BE,
  input  logic [5:0]  NWORDS,
  input  logic [31:0] WR_DATA,
  output logic        WR_POP,
  output logic [31:0] RD_DATA,
  output logic        RD_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        ABORT,
  output wire         FRAME,
  output wire         IRDY,
  output wire  [3:0]  CBE,
  input  logic        TRDY,
  input  logic        DEVSEL,
  inout  wire  [31:0] AD
);
  pci_state_e st;
  logic [31:0] addr_q;
  logic [3:0] cmd_q, be_q;
  logic [5:0] rem;
  logic wr, xfer, expire, start_ok;
  assign wr = cmd_q[0];
  assign xfer = st == DATA && !TRDY && !DEVSEL;
  assign start_ok = START && NWORDS != '0 && NWORDS <= 6'(MAX_WORDS);
  assign WR_POP = xfer && wr;
  assign BUSY = st != IDLE;
  // FRAME rises on the last data phase; RELEASE drives both strobes high before letting go
  assign FRAME = st == IDLE ? 1'bz : !(st == pci_pkg::ADDR || (st == DATA && rem != 6'd1));
  assign IRDY = st == IDLE ? 1'bz : st != DATA;
  assign CBE = st == pci_pkg::ADDR ? cmd_q : st == DATA ? be_q : 4'bz;
  assign AD = st == pci_pkg::ADDR ? addr_q : st == DATA && wr ? WR_DATA : 32'bz;
  pci_devsel_timer #(.TIMEOUT(DEVSEL_TIMEOUT)) u_timer (
    .clk(CLK),
    .rst(REST),
    .clr(st == pci_pkg::ADDR),
    .en(st == DATA),
    .devsel(DEVSEL),
    .expire(expire)
  );
  always_ff @(posedge CLK)
    if (REST) begin
      st <= IDLE;
      RD_DATA <= '0;
      RD_VALID <= 1'b0;
      DONE <= 1'b0;
      ABORT <= 1'b0;
    end else begin
      RD_VALID <= xfer && !wr;
      DONE <= 1'b0;
      ABORT <= 1'b0;
      if (xfer && !wr) RD_DATA <= AD;
      case (st)
        IDLE: if (start_ok) begin
          addr_q <= ADDR;
          cmd_q <= CMD;
          be_q <= BE;
          rem <= NWORDS;
          st <= pci_pkg::ADDR;
        end
        pci_pkg::ADDR: st <= DATA;
        DATA: if (xfer) begin
          if (rem == 6'd1) begin
            st <= RELEASE;
            DONE <= 1'b1;
          end else rem <= rem - 1'b1;
        end else if (expire) begin
          st <= RELEASE;
          ABORT <= 1'b1;
        end
        RELEASE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pci_initiator.sv
// tb_pci_initiator: directed and random bursts against a behavioural PCI target and memory model
module tb_pci_initiator;
  logic CLK = 1'b0, REST = 1'b1, START = 1'b0;
  logic [31:0] ADDR = '0, WR_DATA = '0, RD_DATA, ad_val = '0;
  logic [3:0] CMD = '0, BE = '0;
  logic [5:0] NWORDS = '0;
  logic WR_POP, RD_VALID, BUSY, DONE, ABORT;
  logic TRDY = 1'b1, DEVSEL = 1'b1, ad_en = 1'b0;
  wire FRAME, IRDY;
  wire [3:0] CBE;
  wire [31:0] AD;
  int checks = 0, errors = 0;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] wq [64];
  localparam logic [3:0] WR = pci_pkg::PCI_CMD_WRITE;
  localparam logic [3:0] RD = pci_pkg::PCI_CMD_READ;
  localparam int TMO = 4;
  assign AD = ad_en ? ad_val : 'z;
  pullup (FRAME);
  pullup (IRDY);
  pullup (CBE);
  pullup (AD);
  pci_initiator #(.DEVSEL_TIMEOUT(TMO), .MAX_WORDS(32)) dut (
    .CLK(CLK), .REST(REST), .START(START), .ADDR(ADDR), .CMD(CMD), .BE(BE),
    .NWORDS(NWORDS), .WR_DATA(WR_DATA), .WR_POP(WR_POP), .RD_DATA(RD_DATA),
    .RD_VALID(RD_VALID), .BUSY(BUSY), .DONE(DONE), .ABORT(ABORT), .FRAME(FRAME),
    .IRDY(IRDY), .CBE(CBE), .TRDY(TRDY), .DEVSEL(DEVSEL), .AD(AD)
  );
  always #5 CLK = ~CLK;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask
  function automatic int nextw(input int w);
    return w < 0 ? int'($urandom_range(0, 2)) : w;
  endfunction
  // Released bus lines read as the pull-up value; a driven line shows the driver
  task automatic chk_released(input string tag);
    chk({tag, "_frame"}, FRAME, 1'b1);
    chk({tag, "_irdy"}, IRDY, 1'b1);
    chk({tag, "_cbe"}, CBE, 4'hF);
    chk({tag, "_ad"}, AD, '1);
  endtask
  task automatic burst(input logic [31:0] a, input logic [3:0] c, input logic [3:0] b,
                       input int n, input int wmax, input int rst_at);
    bit wr, claim, xfer, prev_wait, fin;
    int idx, dcyc, waitc;
    logic [31:0] p_ad;
    logic [3:0] p_cbe;
    logic p_fr, p_ir;
    wr = c[0];
    claim = a[31:16] == 16'h0;
    prev_wait = 0;
    fin = 0;
    idx = 0;
    dcyc = 0;
    ADDR = a; CMD = c; BE = b; NWORDS = 6'(n); WR_DATA = wq[0]; START = 1;
    tick();
    START = 0;
    chk("addr_frame", FRAME, 1'b0);
    chk("addr_irdy", IRDY, 1'b1);
    chk("addr_ad", AD, a);
    chk("addr_cbe", CBE, c);
    chk("addr_busy", BUSY, 1'b1);
    waitc = wr ? nextw(wmax) : nextw(wmax) + 1;
    tick();
    while (!fin) begin
      chk("d_irdy", IRDY, 1'b0);
      chk("d_cbe", CBE, b);
      chk("d_frame", FRAME, idx == n - 1);
      chk("d_done", DONE, 1'b0);
      chk("d_abort", ABORT, 1'b0);
      if (!wr && dcyc == 0) chk("turn_ad", AD, '1);
      if (wr) chk("wr_ad", AD, wq[idx]);
      if (prev_wait) begin
        chk("ws_ad", AD, p_ad);
        chk("ws_cbe", CBE, p_cbe);
        chk("ws_frame", FRAME, p_fr);
        chk("ws_irdy", IRDY, p_ir);
      end
      if (dcyc == 0) START = 1;
      if (rst_at == dcyc) REST = 1;
      if (claim) begin
        DEVSEL = 0;
        TRDY = waitc > 0;
        if (waitc > 0) waitc--;
      end else begin
        DEVSEL = 1;
        TRDY = 1;
      end
      xfer = claim && !TRDY;
      if (xfer && !wr) begin
        ad_en = 1;
        ad_val = mem[idx];
      end
      #1;
      chk("pop", WR_POP, xfer && wr);
      if (xfer && wr) mem[idx] = AD;
      prev_wait = claim && TRDY;
      p_ad = AD; p_cbe = CBE; p_fr = FRAME; p_ir = IRDY;
      @(posedge CLK);
      #1;
      ad_en = 0;
      TRDY = 1;
      START = 0;
      if (xfer && wr && idx + 1 < n) WR_DATA = wq[idx + 1];
      if (xfer) begin
        idx++;
        waitc = nextw(wmax);
      end
      dcyc++;
      @(negedge CLK);
      if (REST) begin
        chk_released("rst");
        chk("rst_done", DONE, 1'b0);
        chk("rst_abort", ABORT, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        REST = 0;
        DEVSEL = 1;
        fin = 1;
      end else begin
        chk("rd_valid", RD_VALID, xfer && !wr);
        if (xfer && !wr) chk("rd_data", RD_DATA, ref_mem[idx - 1]);
        if (idx == n) begin
          chk("rel_done", DONE, 1'b1);
          chk("rel_abort", ABORT, 1'b0);
          chk("rel_frame", FRAME, 1'b1);
          chk("rel_irdy", IRDY, 1'b1);
          chk("rel_ad", AD, '1);
          chk("rel_busy", BUSY, 1'b1);
          fin = 1;
        end else if (!claim && dcyc == TMO) begin
          chk("ab_abort", ABORT, 1'b1);
          chk("ab_done", DONE, 1'b0);
          chk("ab_frame", FRAME, 1'b1);
          chk("ab_irdy", IRDY, 1'b1);
          chk("ab_busy", BUSY, 1'b1);
          fin = 1;
        end else if (dcyc > 200) begin
          checks++;
          errors++;
          $error("FAIL budget burst still open after %0d data cycles, required end by %0d", dcyc, 200);
          fin = 1;
        end
      end
    end
    DEVSEL = 1;
    TRDY = 1;
    tick();
    chk_released("idle");
    chk("idle_busy", BUSY, 1'b0);
    chk("idle_done", DONE, 1'b0);
    chk("idle_abort", ABORT, 1'b0);
  endtask
  task automatic mem_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("mem", mem[i], wq[i]);
      ref_mem[i] = wq[i];
    end
  endtask
  task automatic ignored(input int n);
    ADDR = 32'h0; CMD = WR; NWORDS = 6'(n); START = 1;
    tick();
    START = 0;
    chk("ign_busy", BUSY, 1'b0);
    chk_released("ign");
    tick();
    chk("ign_busy2", BUSY, 1'b0);
    chk("ign_frame2", FRAME, 1'b1);
  endtask
  initial begin
    int n;
    bit w;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
      wq[i] = '0;
    end
    tick();
    tick();
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_abort", ABORT, 1'b0);
    chk("rst_rdv", RD_VALID, 1'b0);
    chk("rst_rdd", RD_DATA, 32'h0);
    chk("rst_pop", WR_POP, 1'b0);
    chk_released("rst");
    REST = 0;
    tick();
    wq[0] = 32'h11; wq[1] = 32'h22; wq[2] = 32'h33; wq[3] = 32'h44;
    burst(32'h0000FFFF, WR, 4'h0, 4, 0, -1);
    mem_check(4);
    burst(32'h0000FFFF, RD, 4'h0, 4, 0, -1);
    for (int i = 0; i < 4; i++) wq[i] = $urandom;
    burst(32'h00000100, WR, 4'h3, 4, 2, -1);
    mem_check(4);
    burst(32'h00000100, RD, 4'hC, 4, 2, -1);
    burst(32'h12345678, WR, 4'h0, 4, 0, -1);
    burst(32'h12345678, RD, 4'h0, 4, 1, -1);
    wq[0] = $urandom;
    burst(32'h00000040, WR, 4'h5, 1, 0, -1);
    mem_check(1);
    ignored(0);
    ignored(33);
    for (int i = 0; i < 8; i++) wq[i] = $urandom;
    burst(32'h00000000, WR, 4'h0, 8, 0, 1);
    burst(32'h00000000, WR, 4'h0, 8, 0, -1);
    mem_check(8);
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 32);
      w = $urandom_range(0, 1) == 1;
      for (int i = 0; i < n; i++) wq[i] = $urandom;
      burst({16'h0, 16'($urandom)}, w ? WR : RD, 4'($urandom), n, -1, -1);
      if (w) mem_check(n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
